// File: rtl/fsm_run_ctrl.sv
// Run-length controller: counts a latched number of cycles, then pulses done.
// Supports abort and optional auto-repeat while the run request stays high.
module fsm_run_ctrl #(
    parameter int CNT_W     = 8,
    parameter int REPEAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_run,
    input  logic             in_abort,
    input  logic             in_mode,
    input  logic [CNT_W-1:0] in_len,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_abort,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] ABORT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] last_cnt;
    logic             repeat_req;

    assign last_cnt   = len_q - CNT_ONE;
    assign repeat_req = (REPEAT_EN != 0) && in_mode && in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_run) begin
                        len_q <= in_len;
                        cnt   <= '0;
                        state <= (in_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Abort wins over the terminal count; cnt freezes either way.
                    if (in_abort) begin
                        state <= ABORT;
                    end else if (cnt == last_cnt) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    // A zero-length repeat completes immediately, like a zero-length start.
                    if (repeat_req) begin
                        len_q <= in_len;
                        cnt   <= '0;
                        state <= (in_len == '0) ? DONE : RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_busy  = (state == RUN);
    assign out_done  = (state == DONE);
    assign out_abort = (state == ABORT);
    assign out_cnt   = cnt;

endmodule

// File: tb/tb_fsm_run_ctrl.sv
// Directed-vector bench for fsm_run_ctrl; expected values are hand-derived
// from the cycle timing of each scenario.
module tb_fsm_run_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_run;
    logic             in_abort;
    logic             in_mode;
    logic [CNT_W-1:0] in_len;
    logic             out_busy;
    logic             out_done;
    logic             out_abort;
    logic [CNT_W-1:0] out_cnt;

    int unsigned n_pass;
    int unsigned n_total;

    fsm_run_ctrl #(
        .CNT_W    (CNT_W),
        .REPEAT_EN(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_run   (in_run),
        .in_abort (in_abort),
        .in_mode  (in_mode),
        .in_len   (in_len),
        .out_busy (out_busy),
        .out_done (out_done),
        .out_abort(out_abort),
        .out_cnt  (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int unsigned busy, input int unsigned done,
                              input int unsigned abrt, input int unsigned cnt);
        check_eq({tag, ".busy"},  32'(out_busy),  busy);
        check_eq({tag, ".done"},  32'(out_done),  done);
        check_eq({tag, ".abort"}, 32'(out_abort), abrt);
        check_eq({tag, ".cnt"},   32'(out_cnt),   cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        in_run   = 1'b0;
        in_abort = 1'b0;
        in_mode  = 1'b0;
        in_len   = '0;
        #1;
        expect_out("reset", 0, 0, 0, 0);
        #22;
        rst_n = 1'b1;
        tick();
        expect_out("idle_after_reset", 0, 0, 0, 0);

        // len=5 single shot; in_len changed mid-run must not matter
        in_len = 8'd5;
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        in_len = 8'd9;
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("len5_run%0d", i), 1, 0, 0, i);
            tick();
        end
        expect_out("len5_done", 0, 1, 0, 4);
        tick();
        expect_out("len5_idle", 0, 0, 0, 4);

        // len=0: done right after the start edge
        in_len = 8'd0;
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        expect_out("len0_done", 0, 1, 0, 0);
        tick();
        expect_out("len0_idle", 0, 0, 0, 0);

        // len=1 boundary
        in_len = 8'd1;
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        expect_out("len1_run", 1, 0, 0, 0);
        tick();
        expect_out("len1_done", 0, 1, 0, 0);
        tick();

        // len=10, abort at cnt=3
        in_len = 8'd10;
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        tick();
        tick();
        tick();
        expect_out("abort_pre", 1, 0, 0, 3);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        expect_out("abort_ack", 0, 0, 1, 3);
        tick();
        expect_out("abort_idle", 0, 0, 0, 3);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        expect_out("abort_in_idle_ignored", 0, 0, 0, 3);

        // abort on terminal-count edge: len=4, cnt=3
        in_len = 8'd4;
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        tick();
        tick();
        tick();
        expect_out("tc_pre", 1, 0, 0, 3);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        expect_out("tc_abort", 0, 0, 1, 3);
        tick();
        expect_out("tc_idle", 0, 0, 0, 3);

        // auto-repeat: len=3, in_run held -> done every 4 cycles
        in_mode = 1'b1;
        in_len  = 8'd3;
        in_run  = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            expect_out($sformatf("rep%0d_c0", r), 1, 0, 0, 0);
            tick();
            expect_out($sformatf("rep%0d_c1", r), 1, 0, 0, 1);
            tick();
            expect_out($sformatf("rep%0d_c2", r), 1, 0, 0, 2);
            tick();
            expect_out($sformatf("rep%0d_done", r), 0, 1, 0, 2);
            tick();
        end
        in_run = 1'b0;
        expect_out("rep_last_c0", 1, 0, 0, 0);
        tick();
        tick();
        expect_out("rep_last_c2", 1, 0, 0, 2);
        tick();
        expect_out("rep_last_done", 0, 1, 0, 2);
        tick();
        expect_out("rep_idle", 0, 0, 0, 2);
        in_mode = 1'b0;

        // len=255 does not wrap
        in_len = 8'd255;
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        repeat (254) tick();
        expect_out("len255_last", 1, 0, 0, 254);
        tick();
        expect_out("len255_done", 0, 1, 0, 254);
        tick();

        // asynchronous reset mid-run at cnt=2
        in_len = 8'd6;
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        tick();
        tick();
        expect_out("rst_pre", 1, 0, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0, 0);
        #9;
        rst_n  = 1'b1;
        in_len = 8'd2;
        in_run = 1'b1;
        expect_out("rst_release", 0, 0, 0, 0);
        tick();
        in_run = 1'b0;
        expect_out("post_rst_c0", 1, 0, 0, 0);
        tick();
        expect_out("post_rst_c1", 1, 0, 0, 1);
        tick();
        expect_out("post_rst_done", 0, 1, 0, 1);
        tick();
        expect_out("post_rst_idle", 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fsm_run_ctrl.md
FSM_RUN_CTRL -- requirements
Module: fsm_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the run-length and count paths.
REQ-002 SHALL have parameter REPEAT_EN, default 1; when 0, auto-repeat mode is disabled and in_mode is ignored.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_run, input, 1, start request, sampled level-high.
REQ-006 SHALL have port in_abort, input, 1, cancels an active run.
REQ-007 SHALL have port in_mode, input, 1: 0 = single-shot; 1 = auto-repeat while in_run is held high.
REQ-008 SHALL have port in_len, input, CNT_W, run length in clock cycles, latched at start.
REQ-009 SHALL have port out_busy, output, 1, high while in state RUN.
REQ-010 SHALL have port out_done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port out_abort, output, 1, one-cycle abort-acknowledge pulse.
REQ-012 SHALL have port out_cnt, output, CNT_W, current elapsed-cycle count.

Function
REQ-013 SHALL implement four states: IDLE, RUN, DONE, ABORT; all outputs are registered or decoded from registered state only.
REQ-014 SHALL, in IDLE, on an edge with in_run=1: latch in_len into len_q, clear out_cnt, and go to RUN; if in_len=0, go directly to DONE.
REQ-015 SHALL, in RUN, increment out_cnt by 1 per edge; at the edge where out_cnt = len_q-1, go to DONE.
REQ-016 SHALL give latency such that a start sampled at edge N asserts out_done for exactly the cycle following edge N+len (len=0 -> following edge N).
REQ-017 SHALL hold out_cnt at its final value (len_q-1, or 0 for len=0) during DONE and IDLE until the next start.
REQ-018 SHALL leave DONE after one cycle: go to RUN (reload in_len, clear cnt) if REPEAT_EN=1, in_mode=1 and in_run=1; otherwise go to IDLE.
REQ-019 SHALL, in RUN, on in_abort=1 go to ABORT, freeze out_cnt, and assert out_abort for exactly one cycle; then go to IDLE; no out_done is produced.
REQ-020 SHALL give abort priority over completion when in_abort=1 on the terminal-count edge.
REQ-021 SHALL ignore in_abort in IDLE, DONE and ABORT, and ignore in_run in RUN and ABORT.
REQ-022 SHALL ignore changes of in_len after start; only the latched len_q governs the run.
REQ-023 SHALL handle in_len = 2^CNT_W-1 without overflow; out_cnt never wraps within a run.
REQ-024 SHALL never assert out_done and out_abort in the same cycle; out_busy SHALL be low whenever either is high.

Reset
REQ-025 SHALL, on rst_n=0, immediately (asynchronously) force state IDLE, out_busy=0, out_done=0, out_abort=0, out_cnt=0, len_q=0.
REQ-026 SHALL, on reset mid-run, discard the run with no done or abort pulse.
REQ-027 SHALL, after rst_n release, honour in_run at the first rising edge with rst_n=1.

Verification
REQ-028 SHALL cover: in_len=5, in_run pulsed one cycle at edge N -> out_busy high 5 cycles, out_cnt 0..4, out_done high the cycle after edge N+5, then IDLE.
REQ-029 SHALL cover: in_len=0, in_run pulse -> out_done the cycle after start edge, out_busy never high, out_cnt=0.
REQ-030 SHALL cover: in_len=10, in_abort at cnt=3 -> out_abort one cycle, out_cnt holds 3, no out_done, IDLE next cycle.
REQ-031 SHALL cover: in_mode=1, in_len=3, in_run held high -> out_done every 4 cycles; in_run dropped -> IDLE after the next out_done.
REQ-032 SHALL cover: in_abort asserted on terminal-count edge (in_len=4, cnt=3) -> out_abort only, no out_done.
REQ-033 SHALL cover: rst_n pulsed low 10 ns mid-run at cnt=2 -> all outputs 0 immediately, and a new in_run with in_len=2 completes normally.
